// File: rtl/pulse_sum_scheduler.sv
// pulse_sum_scheduler: round-robin servicing of per-channel event pulses into one saturating up/down counter
module pulse_sum_scheduler #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  parameter logic [N_CH-1:0] DEC_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ev_in,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [N_CH-1:0]  grant,
  output logic             busy,
  output logic             drop_flag,
  output logic             sat_flag
);
  localparam int PW = $clog2(N_CH);
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_grant;
  logic [PW-1:0]    r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop;
  logic             r_sat;
  logic [N_CH-1:0]  w_win;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_cand;
  logic             w_found;
  logic             w_dec;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_nx;
  // pick the first pending channel after the last serviced one, wrapping around
  always_comb begin
    w_win = '0;
    w_idx = r_ptr;
    w_cand = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N_CH);
      if (!w_found && r_pend[w_cand]) begin
        w_found = 1'b1;
        w_idx = w_cand;
        w_win[w_cand] = 1'b1;
      end
    end
  end
  // a clipped update still counts as serviced; only the count stays put
  always_comb begin
    w_dec = |(w_win & DEC_MASK);
    w_sat = w_found && (w_dec ? (r_cnt == '0) : (&r_cnt));
    w_cnt_nx = (!w_found || w_sat) ? r_cnt : (w_dec ? r_cnt - 1'b1 : r_cnt + 1'b1);
  end
  // state update; clear beats everything and swallows that cycle's events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_grant <= '0;
      r_ptr <= PW'(N_CH - 1);
      r_cnt <= '0;
      r_drop <= 1'b0;
      r_sat <= 1'b0;
    end else if (clear) begin
      r_pend <= '0;
      r_grant <= '0;
      r_ptr <= PW'(N_CH - 1);
      r_cnt <= '0;
      r_drop <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_win) | ev_in;
      r_grant <= w_win;
      r_ptr <= w_found ? w_idx : r_ptr;
      r_cnt <= w_cnt_nx;
      r_drop <= r_drop | (|(ev_in & r_pend & ~w_win));
      r_sat <= r_sat | w_sat;
    end
  end
  assign count = r_cnt;
  assign grant = r_grant;
  assign busy = |r_pend;
  assign drop_flag = r_drop;
  assign sat_flag = r_sat;
endmodule
